// File: rtl/fmul_fp32_if.sv
// Start/done handshake bundle for the FMUL execution unit.
// The master issues operands; the slave returns the product.
interface fmul_fp32_if #(parameter int WIDTH = 32);
    logic             valid_input;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             valid_output;
    logic [WIDTH-1:0] y;

    modport master (output valid_input, a, b, input  valid_output, y);
    modport slave  (input  valid_input, a, b, output valid_output, y);
endinterface

// File: rtl/fmul_fp32.sv
// Multi-cycle binary32 multiplier: IDLE -> UNPACK -> MULT -> NORM_ROUND -> DONE.
// Subnormals are flushed to zero; rounding is round-to-nearest-even.
module fmul_fp32 #(
    parameter int WIDTH = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    fmul_fp32_if.slave   bus
);
    typedef enum logic [2:0] {IDLE, UNPACK, MULT, NORM_ROUND, DONE} state_t;
    typedef enum logic [1:0] {K_NORM, K_ZERO, K_INF, K_NAN} kind_t;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
    logic              sign_q, sign_d;
    kind_t             kind_q, kind_d;
    logic [23:0]       sig_a_q, sig_a_d, sig_b_q, sig_b_d;
    logic [7:0]        ea_q, ea_d, eb_q, eb_d;
    logic [47:0]       prod_q, prod_d;
    logic signed [9:0] exp_q, exp_d;
    logic [WIDTH-1:0]  res_q, res_d, y_q, y_d;
    logic              valid_q, valid_d;

    logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic [23:0]       n_sig;
    logic              n_g, n_r, n_s, inc;
    logic signed [9:0] n_exp, r_exp;
    logic [24:0]       rnd;
    logic [22:0]       r_frac;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sign_d  = sign_q;
        kind_d  = kind_q;
        sig_a_d = sig_a_q;
        sig_b_d = sig_b_q;
        ea_d    = ea_q;
        eb_d    = eb_q;
        prod_d  = prod_q;
        exp_d   = exp_q;
        res_d   = res_q;
        y_d     = y_q;
        valid_d = 1'b0;

        a_nan  = (a_q[30:23] == 8'hFF) && (a_q[22:0] != 23'd0);
        b_nan  = (b_q[30:23] == 8'hFF) && (b_q[22:0] != 23'd0);
        a_inf  = (a_q[30:23] == 8'hFF) && (a_q[22:0] == 23'd0);
        b_inf  = (b_q[30:23] == 8'hFF) && (b_q[22:0] == 23'd0);
        a_zero = (a_q[30:23] == 8'h00);
        b_zero = (b_q[30:23] == 8'h00);

        // Normalise the 48-bit product to 24 bits plus guard/round/sticky.
        if (prod_q[47]) begin
            n_sig = prod_q[47:24];
            n_g   = prod_q[23];
            n_r   = prod_q[22];
            n_s   = |prod_q[21:0];
            n_exp = exp_q + 10'sd1;
        end else begin
            n_sig = prod_q[46:23];
            n_g   = prod_q[22];
            n_r   = prod_q[21];
            n_s   = |prod_q[20:0];
            n_exp = exp_q;
        end
        inc = n_g & (n_r | n_s | n_sig[0]);
        rnd = {1'b0, n_sig} + {24'd0, inc};
        if (rnd[24]) begin
            r_frac = rnd[23:1];
            r_exp  = n_exp + 10'sd1;
        end else begin
            r_frac = rnd[22:0];
            r_exp  = n_exp;
        end

        unique case (state_q)
            IDLE: begin
                if (bus.valid_input) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    state_d = UNPACK;
                end
            end
            UNPACK: begin
                sign_d  = a_q[31] ^ b_q[31];
                sig_a_d = {1'b1, a_q[22:0]};
                sig_b_d = {1'b1, b_q[22:0]};
                ea_d    = a_q[30:23];
                eb_d    = b_q[30:23];
                // NaN covers Inf x zero, so Inf and zero below are exclusive.
                if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero))
                    kind_d = K_NAN;
                else if (a_inf || b_inf)
                    kind_d = K_INF;
                else if (a_zero || b_zero)
                    kind_d = K_ZERO;
                else
                    kind_d = K_NORM;
                state_d = MULT;
            end
            MULT: begin
                prod_d  = {24'd0, sig_a_q} * {24'd0, sig_b_q};
                exp_d   = $signed({2'b00, ea_q}) + $signed({2'b00, eb_q}) - 10'sd127;
                state_d = NORM_ROUND;
            end
            NORM_ROUND: begin
                unique case (kind_q)
                    K_NAN:  res_d = QNAN;
                    K_INF:  res_d = {sign_q, 8'hFF, 23'd0};
                    K_ZERO: res_d = {sign_q, 31'd0};
                    default: begin
                        if (r_exp >= 10'sd255)
                            res_d = {sign_q, 8'hFF, 23'd0};
                        else if (r_exp <= 10'sd0)
                            res_d = {sign_q, 31'd0};
                        else
                            res_d = {sign_q, r_exp[7:0], r_frac};
                    end
                endcase
                state_d = DONE;
            end
            DONE: begin
                y_d     = res_q;
                valid_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sign_q  <= 1'b0;
            kind_q  <= K_NORM;
            sig_a_q <= '0;
            sig_b_q <= '0;
            ea_q    <= '0;
            eb_q    <= '0;
            prod_q  <= '0;
            exp_q   <= '0;
            res_q   <= '0;
            y_q     <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sign_q  <= sign_d;
            kind_q  <= kind_d;
            sig_a_q <= sig_a_d;
            sig_b_q <= sig_b_d;
            ea_q    <= ea_d;
            eb_q    <= eb_d;
            prod_q  <= prod_d;
            exp_q   <= exp_d;
            res_q   <= res_d;
            y_q     <= y_d;
            valid_q <= valid_d;
        end
    end

    assign bus.y            = y_q;
    assign bus.valid_output = valid_q;
endmodule

// File: tb/tb_fmul_fp32.sv
// Directed vector bench for fmul_fp32: result values, latency and handshake corners.
module tb_fmul_fp32;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fmul_fp32_if #(.WIDTH(32)) bus ();
    fmul_fp32 #(.WIDTH(32)) dut (.clk(clk), .rst_n(rst), .bus(bus));

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] y;
        string       name;
    } vec_t;
    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Returns on the falling edge just after the capture edge.
    task automatic start(input logic [31:0] a, input logic [31:0] b, input bit sync);
        if (sync) @(negedge clk);
        bus.valid_input = 1'b1;
        bus.a = a;
        bus.b = b;
        @(negedge clk);
        bus.valid_input = 1'b0;
        bus.a = $urandom;
        bus.b = $urandom;
    endtask

    // Pulse must appear only after the fourth edge following capture.
    task automatic expect_result(input logic [31:0] exp, input string name, input bit toggle);
        bit early = 1'b0;
        for (int i = 2; i <= 5; i++) begin
            @(negedge clk);
            if (i < 5 && bus.valid_output) early = 1'b1;
            if (toggle && i < 5) begin
                bus.valid_input = ~bus.valid_input;
                bus.a = $urandom;
                bus.b = $urandom;
            end else begin
                bus.valid_input = 1'b0;
            end
        end
        chk({name, " pulse"}, {31'd0, bus.valid_output & ~early}, 32'd1);
        chk(name, bus.y, exp);
    endtask

    task automatic quiet(input int n, input string name);
        bit seen = 1'b0;
        repeat (n) begin
            @(negedge clk);
            if (bus.valid_output) seen = 1'b1;
        end
        chk(name, {31'd0, seen}, 32'd0);
    endtask

    initial begin
        bus.valid_input = 1'b0;
        bus.a = '0;
        bus.b = '0;

        vecs.push_back('{32'h4000_0000, 32'h3F00_0000, 32'h3F80_0000, "2.0x0.5"});
        vecs.push_back('{32'h3FC0_0000, 32'h4000_0000, 32'h4040_0000, "1.5x2.0"});
        vecs.push_back('{32'h3F00_0000, 32'h3F00_0000, 32'h3E80_0000, "0.5x0.5"});
        vecs.push_back('{32'hC040_0000, 32'h4000_0000, 32'hC0C0_0000, "-3x2"});
        vecs.push_back('{32'h0000_0000, 32'h3F80_0000, 32'h0000_0000, "+0x1"});
        vecs.push_back('{32'h8000_0000, 32'h3F80_0000, 32'h8000_0000, "-0x1"});
        vecs.push_back('{32'h3F80_0000, 32'h7F80_0000, 32'h7F80_0000, "1xInf"});
        vecs.push_back('{32'hFF80_0000, 32'h3F80_0000, 32'hFF80_0000, "-Infx1"});
        vecs.push_back('{32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000, "Infx0"});
        vecs.push_back('{32'h7FC0_0000, 32'h3F80_0000, 32'h7FC0_0000, "NaNx1"});
        vecs.push_back('{32'hFF80_0001, 32'h0000_0000, 32'h7FC0_0000, "sNaNx0"});
        vecs.push_back('{32'h3FFF_FFFF, 32'h3FFF_FFFF, 32'h407F_FFFE, "rne max"});
        vecs.push_back('{32'h3F80_0001, 32'h3FC0_0000, 32'h3FC0_0002, "tie odd up"});
        vecs.push_back('{32'h3F80_0003, 32'h3FC0_0000, 32'h3FC0_0004, "tie even hold"});
        vecs.push_back('{32'h3F80_0001, 32'h3F80_0001, 32'h3F80_0002, "1+ulp sq"});
        vecs.push_back('{32'h7F00_0000, 32'h4000_0000, 32'h7F80_0000, "overflow"});
        vecs.push_back('{32'h0080_0000, 32'h3F00_0000, 32'h0000_0000, "underflow"});
        vecs.push_back('{32'h0000_0001, 32'h3F80_0000, 32'h0000_0000, "subnormal in"});

        repeat (2) @(negedge clk);
        chk("reset y", bus.y, 32'h0);
        chk("reset valid", {31'd0, bus.valid_output}, 32'd0);
        rst = 1'b0;
        quiet(2, "idle no pulse");

        start(32'h3F80_0000, 32'h3F80_0000, 1'b1);
        expect_result(32'h3F80_0000, "1x1", 1'b0);
        quiet(3, "1x1 single pulse");

        foreach (vecs[i]) begin
            start(vecs[i].a, vecs[i].b, 1'b1);
            expect_result(vecs[i].y, vecs[i].name, 1'b0);
        end

        start(32'h4000_0000, 32'h3F00_0000, 1'b1);
        expect_result(32'h3F80_0000, "toggle busy", 1'b1);
        quiet(8, "toggle no extra");
        chk("toggle y held", bus.y, 32'h3F80_0000);

        start(32'h3FC0_0000, 32'h4000_0000, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        quiet(8, "reset abort");
        chk("reset abort y", bus.y, 32'h0);

        start(32'h3F00_0000, 32'h3F00_0000, 1'b1);
        expect_result(32'h3E80_0000, "b2b first", 1'b0);
        start(32'hC040_0000, 32'h4000_0000, 1'b0);
        expect_result(32'hC0C0_0000, "b2b second", 1'b0);
        quiet(4, "b2b no extra");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
